com_result_serializer: RTL

Output stage that sits directly downstream of the vector CPU's data memory. When the CPU raises `COMFlag`, the block captures the R-lane vector currently on the data-memory read port and streams it to the interpreter link one N-bit lane per handshake, lane 0 first. A 2-entry vector buffer lets the CPU keep running while a previous result drains. Overflow is recorded in a sticky flag and never stalls the CPU.

---
 rtl/com_result_serializer_if.sv | 12 +
 rtl/com_result_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/com_result_serializer_if.sv
// Byte-stream link from the result serializer to the interpreter.
// The master drives valid/data; the slave returns ready.
interface com_result_serializer_if #(
  parameter int N = 8
);
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/com_result_serializer.sv
// com_result_serializer: captures an R-lane result vector from the data
// memory read port on COMFlag and streams it one N-bit lane per handshake,
// lane 0 first, through a 2-entry vector buffer.
// Optional feature macro: COM_HEADER_EN prefixes each frame with a one-byte
// sequence number (0, 1, 2, ... wrapping at 2^N).
// All outputs are registered; reset is synchronous and active high.
module com_result_serializer #(
  parameter int N = 8,
  parameter int R = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                COMFlag,
  input  logic [R-1:0][N-1:0] ReadData,
  com_result_serializer_if.master out_if,
  output logic                frame_done,
  output logic                busy,
  output logic                overflow
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(R - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef COM_HEADER_EN
    HDR  = 2'd1,
`endif
    LANE = 2'd2
  } state_t;

  state_t              state_r;
  logic [R-1:0][N-1:0] mem_r [2];
  logic                wptr_r;
  logic                rptr_r;
  logic [1:0]          count_r;
  logic [LW-1:0]       lane_r;
  logic                out_valid_r;
  logic [N-1:0]        out_data_r;
  logic                frame_done_r;
  logic                busy_r;
  logic                overflow_r;
`ifdef COM_HEADER_EN
  logic [N-1:0]        seq_r;
`else
  logic [N-1:0]        next_head0_s;
`endif

  logic                xfer_s;
  logic                last_s;
  logic                pop_s;
  logic                push_s;
  logic                drop_s;
  logic [1:0]          count_nxt_s;
  logic [LW-1:0]       next_lane_s;
  logic [N-1:0]        lane_data_s;

  assign out_if.out_valid = out_valid_r;
  assign out_if.out_data  = out_data_r;
  assign frame_done       = frame_done_r;
  assign busy             = busy_r;
  assign overflow         = overflow_r;

  // Handshake decode, buffer push/pop/drop decisions and next lane data.
  always_comb begin
    xfer_s      = out_valid_r & out_if.out_ready;
    last_s      = (state_r == LANE) && (lane_r == LANE_LAST);
    pop_s       = xfer_s & last_s;
    // A full buffer still accepts a capture when the head pops on the same edge.
    push_s      = COMFlag & ((count_r != 2'd2) | pop_s);
    drop_s      = COMFlag & (count_r == 2'd2) & ~pop_s;
    count_nxt_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
    if (lane_r == LANE_LAST) begin
      next_lane_s = '0;
    end else begin
      next_lane_s = lane_r + LW'(1'b1);
    end
    lane_data_s = mem_r[rptr_r][next_lane_s];
`ifndef COM_HEADER_EN
    // Lane 0 of the vector that becomes head after a pop; with one entry it
    // is the vector being captured on this same edge.
    if (count_r == 2'd2) begin
      next_head0_s = mem_r[~rptr_r][0];
    end else begin
      next_head0_s = ReadData[0];
    end
`endif
  end

  // Vector storage: written at the write pointer on every accepted capture.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wptr_r] <= ReadData;
    end
  end

  // Buffer bookkeeping, frame FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      wptr_r       <= 1'b0;
      rptr_r       <= 1'b0;
      count_r      <= 2'd0;
      lane_r       <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      overflow_r   <= 1'b0;
`ifdef COM_HEADER_EN
      seq_r        <= '0;
`endif
    end else begin
      frame_done_r <= 1'b0;
      count_r      <= count_nxt_s;
      busy_r       <= (count_nxt_s != 2'd0);
      if (push_s) begin
        wptr_r <= ~wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ~rptr_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (count_r != 2'd0) begin
            lane_r      <= '0;
            out_valid_r <= 1'b1;
`ifdef COM_HEADER_EN
            state_r     <= HDR;
            out_data_r  <= seq_r;
`else
            state_r     <= LANE;
            out_data_r  <= mem_r[rptr_r][0];
`endif
          end
        end
`ifdef COM_HEADER_EN
        HDR: begin
          if (xfer_s) begin
            seq_r      <= seq_r + N'(1'b1);
            state_r    <= LANE;
            out_data_r <= mem_r[rptr_r][0];
          end
        end
`endif
        LANE: begin
          if (xfer_s) begin
            lane_r <= next_lane_s;
            if (last_s) begin
              frame_done_r <= 1'b1;
              if (count_nxt_s != 2'd0) begin
`ifdef COM_HEADER_EN
                state_r    <= HDR;
                out_data_r <= seq_r;
`else
                state_r    <= LANE;
                out_data_r <= next_head0_s;
`endif
              end else begin
                state_r     <= IDLE;
                out_valid_r <= 1'b0;
                out_data_r  <= '0;
              end
            end else begin
              out_data_r <= lane_data_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
          lane_r      <= '0;
        end
      endcase
    end
  end

endmodule
